abro_stimulus_checker: RTL and testbench

- Synthesizable driver and checker for the opposite end of the ABRO state-machine interface.
- Drives A, B and a DUT-side reset (R) into an ABRO FSM, then compares the DUT's O and one-hot State outputs every cycle against an internal golden model.
- Runs an exhaustive 16-vector two-step sequence on each start and reports pass/fail, the failing-vector count and the first failing vector.
- Used for on-chip/FPGA self-test of the ABRO block and as a reusable bench component.

---
 rtl/abro_stimulus_checker_if.sv | 30 +++
 rtl/abro_stimulus_checker.sv | 193 +++++++++++++++++++
 tb/tb_abro_stimulus_checker.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/abro_stimulus_checker_if.sv
// Bundle between the ABRO stimulus checker, the ABRO block under test and the host.
// master = checker side; slave = the DUT/host side that returns O/State and drives start.
`timescale 1ns/1ps
interface abro_stimulus_checker_if;
    localparam int unsigned STATE_W = 4;
    localparam int unsigned ERR_W   = 5;

    logic                 start;
    logic                 A;
    logic                 B;
    logic                 dut_reset;
    logic                 O;
    logic [STATE_W-1:0]   State;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [ERR_W-1:0]     err_count;
    logic [STATE_W-1:0]   first_fail_vec;
    logic                 first_fail_valid;

    modport master (
        input  start, O, State,
        output A, B, dut_reset, busy, done, pass, err_count, first_fail_vec, first_fail_valid
    );

    modport slave (
        output start, O, State,
        input  A, B, dut_reset, busy, done, pass, err_count, first_fail_vec, first_fail_valid
    );
endinterface

// File: rtl/abro_stimulus_checker.sv
// Drives all 16 two-step A/B vectors into an ABRO FSM and checks its O/State
// every cycle against a registered golden model; reports pass, error count and first failure.
`timescale 1ns/1ps
module abro_stimulus_checker #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned RST_CYCLES  = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    abro_stimulus_checker_if.master bus
);
    localparam int unsigned CW  = 8;
    localparam int unsigned VW  = 4;
    localparam int unsigned EW  = 5;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RST   = 2'd1;
    localparam logic [1:0] S_STEP1 = 2'd2;
    localparam logic [1:0] S_STEP2 = 2'd3;

    localparam logic [3:0] M_IDLE   = 4'b0001;
    localparam logic [3:0] M_SEEN_A = 4'b0010;
    localparam logic [3:0] M_SEEN_B = 4'b0100;
    localparam logic [3:0] M_DONE   = 4'b1000;

    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);

    logic [1:0]    state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [VW-1:0] vec, vec_d;
    logic          vec_fail, vec_fail_d;
    logic          a_q, a_d, b_q, b_d, r_q, r_d;
    logic          busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic [EW-1:0] err_q, err_d;
    logic [VW-1:0] ffv_q, ffv_d;
    logic          ffvalid_q, ffvalid_d;

    logic [3:0]    m_state, m_next;
    logic          mismatch_c;
    logic          in_step_c;
    logic          fail_now_c;

    // Golden ABRO model, clocked alongside the DUT from the registered stimulus
    always_comb begin
        m_next = m_state;
        case (m_state)
            M_IDLE: begin
                if (a_q && b_q)  m_next = M_DONE;
                else if (a_q)    m_next = M_SEEN_A;
                else if (b_q)    m_next = M_SEEN_B;
            end
            M_SEEN_A: if (b_q) m_next = M_DONE;
            M_SEEN_B: if (a_q) m_next = M_DONE;
            M_DONE:   m_next = M_DONE;
            default:  m_next = M_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)    m_state <= M_IDLE;
        else if (r_q) m_state <= M_IDLE;
        else          m_state <= m_next;
    end

    // Illegal (non-one-hot) DUT states never equal a model state, so they mismatch naturally
    assign in_step_c  = (state == S_STEP1) || (state == S_STEP2);
    assign mismatch_c = (bus.State != m_state) || (bus.O != (m_state == M_DONE));
    assign fail_now_c = vec_fail || mismatch_c;

    // Controller next-state and next-output logic
    always_comb begin
        state_d    = state;
        cnt_d      = cnt + CW'(1);
        vec_d      = vec;
        vec_fail_d = vec_fail || (in_step_c && mismatch_c);
        a_d        = a_q;
        b_d        = b_q;
        r_d        = r_q;
        busy_d     = busy_q;
        done_d     = done_q;
        pass_d     = pass_q;
        err_d      = err_q;
        ffv_d      = ffv_q;
        ffvalid_d  = ffvalid_q;

        case (state)
            S_IDLE: begin
                cnt_d = '0;
                if (bus.start) begin
                    state_d    = S_RST;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    pass_d     = 1'b0;
                    err_d      = '0;
                    ffv_d      = '0;
                    ffvalid_d  = 1'b0;
                    vec_d      = '0;
                    vec_fail_d = 1'b0;
                    a_d        = 1'b0;
                    b_d        = 1'b0;
                    r_d        = 1'b1;
                end
            end
            S_RST: begin
                if (cnt == RST_LAST) begin
                    state_d    = S_STEP1;
                    cnt_d      = '0;
                    r_d        = 1'b0;
                    {a_d, b_d} = vec[3:2];
                end
            end
            S_STEP1: begin
                if (cnt == HOLD_LAST) begin
                    state_d    = S_STEP2;
                    cnt_d      = '0;
                    {a_d, b_d} = vec[1:0];
                end
            end
            S_STEP2: begin
                if (cnt == HOLD_LAST) begin
                    cnt_d = '0;
                    a_d   = 1'b0;
                    b_d   = 1'b0;
                    r_d   = 1'b1;
                    if (fail_now_c) begin
                        err_d = err_q + EW'(1);
                        if (!ffvalid_q) begin
                            ffv_d     = vec;
                            ffvalid_d = 1'b1;
                        end
                    end
                    if (vec == 4'd15) begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (err_d == '0);
                    end else begin
                        state_d    = S_RST;
                        vec_d      = vec + VW'(1);
                        vec_fail_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= '0;
            vec       <= '0;
            vec_fail  <= 1'b0;
            a_q       <= 1'b0;
            b_q       <= 1'b0;
            r_q       <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
            err_q     <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            vec       <= vec_d;
            vec_fail  <= vec_fail_d;
            a_q       <= a_d;
            b_q       <= b_d;
            r_q       <= r_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
            err_q     <= err_d;
            ffv_q     <= ffv_d;
            ffvalid_q <= ffvalid_d;
        end
    end

    assign bus.A                = a_q;
    assign bus.B                = b_q;
    assign bus.dut_reset        = r_q;
    assign bus.busy             = busy_q;
    assign bus.done             = done_q;
    assign bus.pass             = pass_q;
    assign bus.err_count        = err_q;
    assign bus.first_fail_vec   = ffv_q;
    assign bus.first_fail_valid = ffvalid_q;
endmodule

// File: tb/tb_abro_stimulus_checker.sv
// Scoreboard bench: each start pushes the predicted run result; a monitor pops and compares on done.
// Two checkers: defaults with injectable ABRO faults, and HOLD=1/RST=1 with start held high.
`timescale 1ns/1ps
module tb_abro_stimulus_checker;
    typedef struct packed {
        int pass;
        int errs;
        int ffv;
        int ffvalid;
        int len;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    logic reset_f;
    always #5 clock = ~clock;

    abro_stimulus_checker_if bus();
    abro_stimulus_checker_if bus_f();

    abro_stimulus_checker u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    abro_stimulus_checker #(.HOLD_CYCLES(1), .RST_CYCLES(1)) u_fast (
        .clock (clock),
        .reset (reset_f),
        .bus   (bus_f)
    );

    int vectors     = 0;
    int miscompares = 0;
    exp_t sb[$];

    // ABRO block under test: 0 good, 1 O stuck 0, 2 State stuck 0000,
    // 3 SEEN_A ignores B, 4 SEEN_B ignores A
    int tmode = 0;
    logic [3:0] t_state, tf_state;

    always @(posedge clock) begin
        if (bus.dut_reset) t_state <= 4'b0001;
        else case (t_state)
            4'b0001: t_state <= (bus.A && bus.B) ? 4'b1000 : bus.A ? 4'b0010 : bus.B ? 4'b0100 : 4'b0001;
            4'b0010: if (bus.B && tmode != 3) t_state <= 4'b1000;
            4'b0100: if (bus.A && tmode != 4) t_state <= 4'b1000;
            default: t_state <= t_state;
        endcase
    end
    assign bus.O     = (tmode == 1) ? 1'b0 : (t_state == 4'b1000);
    assign bus.State = (tmode == 2) ? 4'b0000 : t_state;

    always @(posedge clock) begin
        if (bus_f.dut_reset) tf_state <= 4'b0001;
        else case (tf_state)
            4'b0001: tf_state <= (bus_f.A && bus_f.B) ? 4'b1000 : bus_f.A ? 4'b0010 : bus_f.B ? 4'b0100 : 4'b0001;
            4'b0010: if (bus_f.B) tf_state <= 4'b1000;
            4'b0100: if (bus_f.A) tf_state <= 4'b1000;
            default: tf_state <= tf_state;
        endcase
    end
    assign bus_f.O     = (tf_state == 4'b1000);
    assign bus_f.State = tf_state;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ABRO as "has seen A and has seen B"; each fault mode as the set of vectors it breaks
    function automatic bit vec_fails(input int mode, input logic [3:0] v);
        bit a1 = v[3];
        bit b1 = v[2];
        bit a2 = v[1];
        bit b2 = v[0];
        bit both = (a1 | a2) & (b1 | b2);
        case (mode)
            1:       return both;
            2:       return 1'b1;
            3:       return a1 & ~b1 & b2;
            4:       return b1 & ~a1 & a2;
            default: return 1'b0;
        endcase
    endfunction

    function automatic exp_t predict(input int mode, input int r, input int h);
        exp_t e;
        int first = -1;
        e.errs = 0;
        for (int v = 0; v < 16; v++) begin
            if (vec_fails(mode, 4'(v))) begin
                e.errs++;
                if (first < 0) first = v;
            end
        end
        e.pass    = (e.errs == 0) ? 1 : 0;
        e.ffvalid = (e.errs > 0) ? 1 : 0;
        e.ffv     = (first < 0) ? 0 : first;
        e.len     = 16 * (r + 2 * h);
        return e;
    endfunction

    // Expected {A,B,dut_reset} k cycles after the accepting edge
    function automatic logic [2:0] exp_stim(input int k, input int r, input int h);
        int per = r + 2 * h;
        int p = k % per;
        logic [3:0] v;
        v = 4'(k / per);
        if (k >= 16 * per || p < r) return 3'b001;
        if (p < r + h)              return {v[3], v[2], 1'b0};
        return {v[1], v[0], 1'b0};
    endfunction

    // Main monitor: tracks stimulus waveform and pops the scoreboard on done
    initial begin
        int cyc = 0;
        bit stim_bad = 0;
        logic busy_prev = 1'b0;
        logic done_prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clock);
            if (!reset) begin
                if (bus.busy && !busy_prev) begin
                    cyc = 0;
                    stim_bad = 0;
                end else begin
                    cyc++;
                end
                if (bus.busy || (bus.done && !done_prev))
                    if ({bus.A, bus.B, bus.dut_reset} != exp_stim(cyc, 2, 4)) stim_bad = 1;
                if (bus.done && !done_prev) begin
                    if (sb.size() == 0) begin
                        check("unexpected_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("pass", bus.pass, e.pass);
                        check("err_count", bus.err_count, e.errs);
                        check("first_fail_vec", bus.first_fail_vec, e.ffv);
                        check("first_fail_valid", bus.first_fail_valid, e.ffvalid);
                        check("run_len", cyc, e.len);
                        check("busy_at_done", bus.busy, 0);
                        check("stim_seq", int'(stim_bad), 0);
                    end
                end
            end
            busy_prev = bus.busy;
            done_prev = bus.done;
        end
    end

    // Fast instance monitor: start held high, back-to-back runs
    int fdone_n = 0;
    initial begin
        int fcyc = 0;
        bit f_bad = 0;
        bit restart_chk = 0;
        logic fbusy_prev = 1'b0;
        logic fdone_prev = 1'b0;
        exp_t ef;
        ef = predict(0, 1, 1);
        forever begin
            @(negedge clock);
            if (!reset_f) begin
                if (restart_chk) begin
                    restart_chk = 0;
                    check("fast_restart_busy", bus_f.busy, 1);
                    check("fast_done_clear", bus_f.done, 0);
                end
                if (bus_f.busy && !fbusy_prev) begin
                    fcyc = 0;
                    f_bad = 0;
                end else begin
                    fcyc++;
                end
                if (bus_f.busy || (bus_f.done && !fdone_prev))
                    if ({bus_f.A, bus_f.B, bus_f.dut_reset} != exp_stim(fcyc, 1, 1)) f_bad = 1;
                if (bus_f.done && !fdone_prev) begin
                    check("fast_run_len", fcyc, ef.len);
                    check("fast_pass", bus_f.pass, ef.pass);
                    check("fast_err_count", bus_f.err_count, ef.errs);
                    check("fast_stim_seq", int'(f_bad), 0);
                    fdone_n++;
                    restart_chk = 1;
                end
            end
            fbusy_prev = bus_f.busy;
            fdone_prev = bus_f.done;
        end
    end

    task automatic issue(input int mode, input bit check_hold);
        @(negedge clock);
        if (check_hold) check("done_hold", bus.done, 1);
        tmode = mode;
        sb.push_back(predict(mode, 2, 4));
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        check("accept_busy", bus.busy, 1);
        check("accept_done_clr", bus.done, 0);
    endtask

    // Wait for the run to drain, with one stray start pulse while busy
    task automatic wait_done(input int spur);
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            bus.start = (n == spur);
            @(negedge clock);
            n++;
        end
        bus.start = 1'b0;
        if (sb.size() != 0) begin
            check("run_timeout", 0, 1);
            sb.delete();
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_A"}, bus.A, 0);
        check({tag, "_B"}, bus.B, 0);
        check({tag, "_dut_reset"}, bus.dut_reset, 1);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_done"}, bus.done, 0);
        check({tag, "_pass"}, bus.pass, 0);
        check({tag, "_err_count"}, bus.err_count, 0);
        check({tag, "_first_fail_vec"}, bus.first_fail_vec, 0);
        check({tag, "_first_fail_valid"}, bus.first_fail_valid, 0);
    endtask

    initial begin
        reset = 1'b1;
        reset_f = 1'b1;
        bus.start = 1'b0;
        bus_f.start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_vals("rst");
        @(negedge clock);
        reset = 1'b0;
        reset_f = 1'b0;
        bus_f.start = 1'b1;
        repeat (3) @(negedge clock);

        // Directed: good DUT then each fault
        issue(0, 0);
        wait_done(int'($urandom_range(10, 140)));
        for (int m = 1; m <= 4; m++) begin
            issue(m, 1);
            wait_done(int'($urandom_range(10, 140)));
        end

        // Randomised fault modes and idle gaps
        for (int i = 0; i < 6; i++) begin
            repeat ($urandom_range(0, 5)) @(negedge clock);
            issue(int'($urandom_range(0, 4)), 1);
            wait_done(int'($urandom_range(10, 140)));
        end

        // Asynchronous abort mid-run (inside vector 5 step1, B=1)
        issue(0, 1);
        repeat (52) @(negedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        #1 check_reset_vals("abort");
        sb.delete();
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        issue(0, 0);
        wait_done(int'($urandom_range(10, 140)));

        check("fast_runs_seen", int'(fdone_n >= 3), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
